// File: rtl/alu_arbiter_if.sv
// Shared types plus the two bus interfaces around alu_arbiter:
//   alu_file_if    - connection to the combinational ALU (tb modport drives it)
//   alu_arbiter_if - the two requesters' request/response channels
package alu_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011
    } aluop_t;
endpackage

interface alu_file_if;
    import alu_arbiter_pkg::*;
    word_t  porta;
    word_t  portb;
    aluop_t aluop;
    word_t  outport;
    logic   negative;
    logic   overflow;
    logic   zero;

    modport alu (input porta, portb, aluop, output outport, negative, overflow, zero);
    modport tb  (output porta, portb, aluop, input outport, negative, overflow, zero);
endinterface

interface alu_arbiter_if;
    import alu_arbiter_pkg::*;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    word_t      req0_porta, req0_portb, req1_porta, req1_portb;
    aluop_t     req0_aluop, req1_aluop;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    word_t      rsp0_result, rsp1_result;
    logic [2:0] rsp0_flags, rsp1_flags;

    // requester side
    modport master (
        output req0_valid, req0_porta, req0_portb, req0_aluop,
        output req1_valid, req1_porta, req1_portb, req1_aluop,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_flags,
        input  rsp1_valid, rsp1_result, rsp1_flags
    );
    // arbiter side
    modport slave (
        input  req0_valid, req0_porta, req0_portb, req0_aluop,
        input  req1_valid, req1_porta, req1_portb, req1_aluop,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_flags,
        output rsp1_valid, rsp1_result, rsp1_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters
// (0: execute stage, 1: aux unit). Round-robin (RR_EN_P=1) or fixed priority
// with req0 winning (RR_EN_P=0). One result is outstanding at most; it is
// registered at the accepting edge and held until the owner drains it.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned RR_EN_P = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    alu_arbiter_if.slave      arb,
    alu_file_if.tb            alu
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant0_cnt,
    output logic [CNT_W-1:0]  grant1_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

    state_t     state_q, state_d;
    logic       last_grant_q;
    logic       grant0, grant1;
    logic       may_accept;
    logic       hs0, hs1;
    word_t      porta_q, portb_q;
    aluop_t     aluop_q;
    word_t      result0_q, result1_q;
    logic [2:0] flags0_q, flags1_q;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("alu_arbiter: CNT_W must be at least 1");
    end

    // Grant selection from the valids and the last completed grant
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb.req0_valid && arb.req1_valid) begin
            if ((RR_EN_P != 0) && (last_grant_q == 1'b0)) grant1 = 1'b1;
            else                                          grant0 = 1'b1;
        end else if (arb.req0_valid) begin
            grant0 = 1'b1;
        end else if (arb.req1_valid) begin
            grant1 = 1'b1;
        end
    end

    // Acceptance: free slot, or the held result drains this very cycle
    always_comb begin
        may_accept = (state_q == IDLE)
                   || ((state_q == HOLD0) && arb.rsp0_ready)
                   || ((state_q == HOLD1) && arb.rsp1_ready);
        arb.req0_ready = may_accept && grant0;
        arb.req1_ready = may_accept && grant1;
        hs0 = arb.req0_valid && arb.req0_ready;
        hs1 = arb.req1_valid && arb.req1_ready;
    end

    // FSM next state: new accept wins over plain drain
    always_comb begin
        state_d = state_q;
        if (hs0)                                  state_d = HOLD0;
        else if (hs1)                             state_d = HOLD1;
        else if ((state_q != IDLE) && may_accept) state_d = IDLE;
    end

    // FSM state and round-robin history
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (hs0)      last_grant_q <= 1'b0;
            else if (hs1) last_grant_q <= 1'b1;
        end
    end

    // ALU operand mux follows the grant, otherwise replays the last value
    always_comb begin
        alu.porta = porta_q;
        alu.portb = portb_q;
        alu.aluop = aluop_q;
        if (grant0) begin
            alu.porta = arb.req0_porta;
            alu.portb = arb.req0_portb;
            alu.aluop = arb.req0_aluop;
        end else if (grant1) begin
            alu.porta = arb.req1_porta;
            alu.portb = arb.req1_portb;
            alu.aluop = arb.req1_aluop;
        end
    end

    // Remember the mux value so an ungranted cycle does not toggle the ALU
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            porta_q <= '0;
            portb_q <= '0;
            aluop_q <= ALU_ADD;
        end else begin
            porta_q <= alu.porta;
            portb_q <= alu.portb;
            aluop_q <= alu.aluop;
        end
    end

    // Capture ALU result and flags for the requester that handshook
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            result0_q <= '0;
            result1_q <= '0;
            flags0_q  <= '0;
            flags1_q  <= '0;
        end else begin
            if (hs0) begin
                result0_q <= alu.outport;
                flags0_q  <= {alu.negative, alu.overflow, alu.zero};
            end
            if (hs1) begin
                result1_q <= alu.outport;
                flags1_q  <= {alu.negative, alu.overflow, alu.zero};
            end
        end
    end

    // Response channel outputs; valid only toward the owner
    always_comb begin
        arb.rsp0_valid  = (state_q == HOLD0);
        arb.rsp1_valid  = (state_q == HOLD1);
        arb.rsp0_result = result0_q;
        arb.rsp1_result = result1_q;
        arb.rsp0_flags  = flags0_q;
        arb.rsp1_flags  = flags1_q;
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating grant and contention statistics
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            grant0_cnt   <= '0;
            grant1_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (hs0 && (grant0_cnt != '1)) grant0_cnt <= grant0_cnt + 1'b1;
            if (hs1 && (grant1_cnt != '1)) grant1_cnt <= grant1_cnt + 1'b1;
            if (arb.req0_valid && arb.req1_valid && may_accept && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a round-robin and a fixed-priority instance run
// in lockstep on the same stimulus, each checked against a transaction-level
// model. Define ALU_ARB_STATS_EN to also check the statistics counters.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned CW = 2;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic   v0 = 1'b0, v1 = 1'b0, r0 = 1'b1, r1 = 1'b1;
    word_t  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    aluop_t op0 = ALU_ADD, op1 = ALU_ADD;

    int checks = 0;
    int failures = 0;

    alu_arbiter_if rq_rr();
    alu_arbiter_if rq_fp();
    alu_file_if    alu_rr();
    alu_file_if    alu_fp();

    assign rq_rr.req0_valid = v0;  assign rq_fp.req0_valid = v0;
    assign rq_rr.req1_valid = v1;  assign rq_fp.req1_valid = v1;
    assign rq_rr.req0_porta = a0;  assign rq_fp.req0_porta = a0;
    assign rq_rr.req0_portb = b0;  assign rq_fp.req0_portb = b0;
    assign rq_rr.req1_porta = a1;  assign rq_fp.req1_porta = a1;
    assign rq_rr.req1_portb = b1;  assign rq_fp.req1_portb = b1;
    assign rq_rr.req0_aluop = op0; assign rq_fp.req0_aluop = op0;
    assign rq_rr.req1_aluop = op1; assign rq_fp.req1_aluop = op1;
    assign rq_rr.rsp0_ready = r0;  assign rq_fp.rsp0_ready = r0;
    assign rq_rr.rsp1_ready = r1;  assign rq_fp.rsp1_ready = r1;

    // Behavioural ALU: {neg, over, zero, result}
    function automatic logic [34:0] alu_model(aluop_t op, word_t a, word_t b);
        word_t r;
        logic  ov;
        ov = 1'b0;
        case (op)
            ALU_ADD:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'b0, a < b};
            default:  r = '0;
        endcase
        return {r[31], ov, (r == '0), r};
    endfunction

    assign {alu_rr.negative, alu_rr.overflow, alu_rr.zero, alu_rr.outport} =
        alu_model(alu_rr.aluop, alu_rr.porta, alu_rr.portb);
    assign {alu_fp.negative, alu_fp.overflow, alu_fp.zero, alu_fp.outport} =
        alu_model(alu_fp.aluop, alu_fp.porta, alu_fp.portb);

`ifdef ALU_ARB_STATS_EN
    logic [CW-1:0] g0c_rr, g1c_rr, cc_rr, g0c_fp, g1c_fp, cc_fp;
`endif

    alu_arbiter #(.RR_EN_P(1), .CNT_W(CW)) dut_rr (
        .CLK(CLK), .nRST(nRST), .arb(rq_rr), .alu(alu_rr)
`ifdef ALU_ARB_STATS_EN
        , .grant0_cnt(g0c_rr), .grant1_cnt(g1c_rr), .conflict_cnt(cc_rr)
`endif
    );

    alu_arbiter #(.RR_EN_P(0), .CNT_W(CW)) dut_fp (
        .CLK(CLK), .nRST(nRST), .arb(rq_fp), .alu(alu_fp)
`ifdef ALU_ARB_STATS_EN
        , .grant0_cnt(g0c_fp), .grant1_cnt(g1c_fp), .conflict_cnt(cc_fp)
`endif
    );

    // Transaction-level model, index 0 = round-robin DUT, 1 = fixed priority
    int         owner[2];      // -1: nothing held, else requester holding a result
    int         lastg[2];
    word_t      mres[2][2];
    logic [2:0] mflg[2][2];
    int         mg0[2], mg1[2], mcc[2];
    int         pend_g[2];
    bit         pend_may[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1;
            lastg[d] = 1;
            mg0[d] = 0; mg1[d] = 0; mcc[d] = 0;
            for (int k = 0; k < 2; k++) begin
                mres[d][k] = '0;
                mflg[d][k] = '0;
            end
        end
    endtask

    function automatic int pick(int d);
        if (v0 && v1) return (d == 0) ? ((lastg[d] == 0) ? 1 : 0) : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic int sat(int c);
        return (c >= (1 << CW) - 1) ? (1 << CW) - 1 : c + 1;
    endfunction

    task automatic pre_check(input int d, input logic rdy0, input logic rdy1,
                             input word_t pa, input word_t pb, input aluop_t po);
        bit may;
        int g;
        may = (owner[d] == -1) || (owner[d] == 0 && r0) || (owner[d] == 1 && r1);
        g = pick(d);
        check($sformatf("d%0d_req0_ready", d), rdy0, may && (g == 0));
        check($sformatf("d%0d_req1_ready", d), rdy1, may && (g == 1));
        if (g != -1) begin
            check($sformatf("d%0d_alu_porta", d), pa, (g == 0) ? a0 : a1);
            check($sformatf("d%0d_alu_portb", d), pb, (g == 0) ? b0 : b1);
            check($sformatf("d%0d_alu_op", d), po, (g == 0) ? op0 : op1);
        end
        pend_may[d] = may;
        pend_g[d] = g;
    endtask

    task automatic model_edge(input int d);
        logic [34:0] m;
        if (pend_may[d]) begin
            if (v0 && v1) mcc[d] = sat(mcc[d]);
            owner[d] = -1;
            if (pend_g[d] != -1) begin
                m = (pend_g[d] == 0) ? alu_model(op0, a0, b0) : alu_model(op1, a1, b1);
                owner[d] = pend_g[d];
                lastg[d] = pend_g[d];
                mres[d][pend_g[d]] = m[31:0];
                mflg[d][pend_g[d]] = m[34:32];
                if (pend_g[d] == 0) mg0[d] = sat(mg0[d]);
                else                mg1[d] = sat(mg1[d]);
            end
        end
    endtask

    task automatic post_check(input int d, input logic vo0, input logic vo1,
                              input word_t ro0, input word_t ro1,
                              input logic [2:0] fo0, input logic [2:0] fo1);
        check($sformatf("d%0d_rsp0_valid", d), vo0, owner[d] == 0);
        check($sformatf("d%0d_rsp1_valid", d), vo1, owner[d] == 1);
        if (owner[d] == 0) begin
            check($sformatf("d%0d_rsp0_result", d), ro0, mres[d][0]);
            check($sformatf("d%0d_rsp0_flags", d), fo0, mflg[d][0]);
        end
        if (owner[d] == 1) begin
            check($sformatf("d%0d_rsp1_result", d), ro1, mres[d][1]);
            check($sformatf("d%0d_rsp1_flags", d), fo1, mflg[d][1]);
        end
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic stats_check();
        check("rr_grant0_cnt", g0c_rr, mg0[0]);
        check("rr_grant1_cnt", g1c_rr, mg1[0]);
        check("rr_conflict_cnt", cc_rr, mcc[0]);
        check("fp_grant0_cnt", g0c_fp, mg0[1]);
        check("fp_grant1_cnt", g1c_fp, mg1[1]);
        check("fp_conflict_cnt", cc_fp, mcc[1]);
    endtask
`endif

    // One clock cycle: inputs already applied; checks before and after the edge
    task automatic cycle();
        #1;
        pre_check(0, rq_rr.req0_ready, rq_rr.req1_ready, alu_rr.porta, alu_rr.portb, alu_rr.aluop);
        pre_check(1, rq_fp.req0_ready, rq_fp.req1_ready, alu_fp.porta, alu_fp.portb, alu_fp.aluop);
        @(posedge CLK);
        model_edge(0);
        model_edge(1);
        #1;
        post_check(0, rq_rr.rsp0_valid, rq_rr.rsp1_valid, rq_rr.rsp0_result,
                   rq_rr.rsp1_result, rq_rr.rsp0_flags, rq_rr.rsp1_flags);
        post_check(1, rq_fp.rsp0_valid, rq_fp.rsp1_valid, rq_fp.rsp0_result,
                   rq_fp.rsp1_result, rq_fp.rsp0_flags, rq_fp.rsp1_flags);
`ifdef ALU_ARB_STATS_EN
        stats_check();
`endif
    endtask

    task automatic reset_values_check(input string tag);
        check({tag, "_rr_rsp0_valid"}, rq_rr.rsp0_valid, 1'b0);
        check({tag, "_rr_rsp1_valid"}, rq_rr.rsp1_valid, 1'b0);
        check({tag, "_rr_rsp0_result"}, rq_rr.rsp0_result, 32'h0);
        check({tag, "_rr_rsp1_result"}, rq_rr.rsp1_result, 32'h0);
        check({tag, "_rr_rsp0_flags"}, rq_rr.rsp0_flags, 3'b000);
        check({tag, "_rr_req0_ready"}, rq_rr.req0_ready, 1'b0);
        check({tag, "_rr_porta"}, alu_rr.porta, 32'h0);
        check({tag, "_rr_aluop"}, alu_rr.aluop, ALU_ADD);
        check({tag, "_fp_rsp0_valid"}, rq_fp.rsp0_valid, 1'b0);
        check({tag, "_fp_rsp0_result"}, rq_fp.rsp0_result, 32'h0);
    endtask

    aluop_t ops[10] = '{ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
                        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};
    logic prev_rr0;

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(negedge CLK);
        reset_values_check("reset");
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Single request: ADD 5 + 7
        v0 = 1'b1; a0 = 32'd5; b0 = 32'd7; op0 = ALU_ADD; r0 = 1'b1;
        cycle();
        check("add_result", rq_rr.rsp0_result, 32'd12);
        check("add_flags", rq_rr.rsp0_flags, 3'b000);
        check("add_valid", rq_rr.rsp0_valid, 1'b1);
        v0 = 1'b0;
        cycle();

        // Both requesting every cycle with ready responses
        v0 = 1'b1; v1 = 1'b1; r0 = 1'b1; r1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            op0 = ops[$urandom_range(0, 9)]; op1 = ops[$urandom_range(0, 9)];
            prev_rr0 = rq_rr.rsp0_valid;
            cycle();
            if (i > 0) check("rr_alternate", rq_rr.rsp0_valid ^ prev_rr0, 1'b1);
            check("fp_always0", rq_fp.rsp0_valid, 1'b1);
        end
        v0 = 1'b0; v1 = 1'b0;
        cycle();

        // req1 SUB 3-5 held with rsp1_ready low while req0 waits
        v1 = 1'b1; a1 = 32'd3; b1 = 32'd5; op1 = ALU_SUB; r1 = 1'b0;
        cycle();
        v1 = 1'b0; v0 = 1'b1; a0 = 32'd40; b0 = 32'd2; op0 = ALU_ADD;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("hold_result", rq_rr.rsp1_result, 32'hFFFF_FFFE);
            check("hold_flags", rq_rr.rsp1_flags, 3'b100);
            check("hold_fp_result", rq_fp.rsp1_result, 32'hFFFF_FFFE);
        end
        r1 = 1'b1;
        cycle();
        check("drain_accept", rq_rr.rsp0_result, 32'd42);

        // Overflow and zero flags
        a0 = 32'h7FFF_FFFF; b0 = 32'd1; op0 = ALU_ADD; r0 = 1'b1;
        cycle();
        check("ovf_result", rq_rr.rsp0_result, 32'h8000_0000);
        check("ovf_flags", rq_rr.rsp0_flags, 3'b110);
        a0 = 32'd9; b0 = 32'd9; op0 = ALU_SUB;
        cycle();
        check("zero_result", rq_rr.rsp0_result, 32'h0);
        check("zero_flags", rq_rr.rsp0_flags, 3'b001);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            r0 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 3) != 0);
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = $urandom;
            op0 = ops[$urandom_range(0, 9)]; op1 = ops[$urandom_range(0, 9)];
            cycle();
        end

        // Asynchronous reset while holding a result for req0
        v1 = 1'b0; v0 = 1'b1; r0 = 1'b0; r1 = 1'b1;
        a0 = 32'd100; b0 = 32'd1; op0 = ALU_SUB;
        cycle();
        check("pre_reset_hold", rq_rr.rsp0_valid, 1'b1);
        v0 = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        reset_values_check("async");
        model_reset();
        @(posedge CLK); #1;
        check("in_reset_no_rsp", rq_rr.rsp0_valid, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        r0 = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Contended req0 handshakes (drives counters to saturation when enabled)
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            cycle();
        end
        v0 = 1'b0; v1 = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
